// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Brings a PLL up and keeps it there. It pulses the PLL reset,
//            waits for lock with a timeout, and qualifies lock over a
//            stability window. It retries on timeout or loss of lock up to
//            MAX_RETRIES times and then parks in FAULT. It is driven by an
//            HPS PIO command word and reports through an HPS PIO status word.
// Ports    : clk_clk     - system clock
//            reset_reset - asynchronous active-high reset
//            cmd_in      - bit0 start (rising edge), bit1 abort (level)
//            pll_locked  - raw PLL lock, asynchronous to clk_clk
//            pll_rst     - PLL areset, active-high
//            locked_out  - high only while LOCKED
//            status_out  - [0] locked, [1] busy, [2] fault, [3] sticky LOL,
//                          [6:4] state, [15:8] retries, [31:16] LOL count
// Options  : PLL_LOCK_SEQ_LOL_COUNT_EN - enables the 16-bit saturating
//            loss-of-lock event counter in status_out[31:16]. When it is not
//            defined, that field reads as zero.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] cmd_in,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic        locked_out,
    output logic [31:0] status_out
);

    localparam int c_MAX_A   = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int c_CNT_MAX = (c_MAX_A > TIMEOUT_CYCLES) ? c_MAX_A : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_CNT_MAX);
    localparam logic [7:0]         c_MAX_RTRY = 8'(MAX_RETRIES);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ARST   = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_QUAL   = 3'd3;
    localparam logic [2:0] c_ST_LOCKED = 3'd4;
    localparam logic [2:0] c_ST_FAULT  = 3'd5;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_retry;
    logic               r_sticky;
    logic               r_sync1, r_sync2;
    logic               r_cmd_q, r_cmd_prev;
    logic               r_pll_rst, r_locked;
    logic [31:0]        r_status;

    logic [2:0]  w_state_next;
    logic        w_cnt_clr;
    logic [7:0]  w_retry_next;
    logic        w_sticky_next;
    logic        w_lol_evt;
    logic        w_start_clr;
    logic        w_retry_req;
    logic        w_start, w_abort, w_lock, w_active;
    logic        w_pll_rst_next, w_locked_next, w_busy_next, w_fault_next;
    logic [15:0] w_lol_field;
    logic [31:0] w_status_next;
    logic        w_unused_cmd;

    assign w_unused_cmd = ^cmd_in[31:2];
    assign w_lock       = r_sync2;
    assign w_start      = r_cmd_q & ~r_cmd_prev;
    assign w_abort      = cmd_in[1];
    assign w_active     = (r_state == c_ST_ARST) || (r_state == c_ST_WAIT) ||
                          (r_state == c_ST_QUAL) || (r_state == c_ST_LOCKED);

    // Lock synchronizer and start edge register. The edge history resets
    // to 1 so that a start bit held through reset is not seen as an edge.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_cmd_q    <= 1'b1;
            r_cmd_prev <= 1'b1;
        end else begin
            r_sync1    <= pll_locked;
            r_sync2    <= r_sync1;
            r_cmd_q    <= cmd_in[0];
            r_cmd_prev <= r_cmd_q;
        end
    end

    // State register, shared counter, bookkeeping and registered outputs
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_retry    <= 8'd0;
            r_sticky   <= 1'b0;
            r_pll_rst  <= 1'b1;
            r_locked   <= 1'b0;
            r_status   <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_retry    <= w_retry_next;
            r_sticky   <= w_sticky_next;
            r_pll_rst  <= w_pll_rst_next;
            r_locked   <= w_locked_next;
            r_status   <= w_status_next;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Next-state logic. Abort outranks start, and start outranks all
    // per-state events.
    always_comb begin : p_next
        w_state_next  = r_state;
        w_cnt_clr     = 1'b0;
        w_retry_next  = r_retry;
        w_sticky_next = r_sticky;
        w_lol_evt     = 1'b0;
        w_start_clr   = 1'b0;
        w_retry_req   = 1'b0;
        if (w_abort) begin
            if (w_active) begin
                w_state_next = c_ST_IDLE;
                w_cnt_clr    = 1'b1;
            end
        end else if (w_start) begin
            w_state_next  = c_ST_ARST;
            w_cnt_clr     = 1'b1;
            w_retry_next  = 8'd0;
            w_sticky_next = 1'b0;
            w_start_clr   = 1'b1;
        end else begin
            case (r_state)
                c_ST_ARST: begin
                    if (r_cnt == c_RST_LAST) begin
                        w_state_next = c_ST_WAIT;
                        w_cnt_clr    = 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (w_lock) begin
                        w_state_next = c_ST_QUAL;
                        w_cnt_clr    = 1'b1;
                    end else if (r_cnt == c_TO_LAST) begin
                        w_retry_req = 1'b1;
                    end
                end
                c_ST_QUAL: begin
                    // A single low sample restarts the whole wait, timeout included
                    if (!w_lock) begin
                        w_state_next = c_ST_WAIT;
                        w_cnt_clr    = 1'b1;
                    end else if (r_cnt == c_STB_LAST) begin
                        w_state_next = c_ST_LOCKED;
                        w_cnt_clr    = 1'b1;
                    end
                end
                c_ST_LOCKED: begin
                    if (!w_lock) begin
                        w_sticky_next = 1'b1;
                        w_lol_evt     = 1'b1;
                        w_retry_req   = 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_retry_req) begin
                w_cnt_clr = 1'b1;
                if (r_retry < c_MAX_RTRY) begin
                    w_retry_next = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
                    w_state_next = c_ST_ARST;
                end else begin
                    w_state_next = c_ST_FAULT;
                end
            end
        end
    end

`ifdef PLL_LOCK_SEQ_LOL_COUNT_EN
    logic [15:0] r_lol_cnt;
    logic [15:0] w_lol_next;

    always_comb begin : p_lol
        w_lol_next = r_lol_cnt;
        if (w_start_clr) begin
            w_lol_next = 16'd0;
        end else if (w_lol_evt && (r_lol_cnt != 16'hFFFF)) begin
            w_lol_next = r_lol_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_lol_cnt <= 16'd0;
        end else begin
            r_lol_cnt <= w_lol_next;
        end
    end

    assign w_lol_field = w_lol_next;
`else
    logic w_unused_lol;
    assign w_unused_lol = w_lol_evt ^ w_start_clr;
    assign w_lol_field  = 16'd0;
`endif

    // Output decode from the next state, so every output is a flop
    always_comb begin : p_out
        w_pll_rst_next = (w_state_next == c_ST_IDLE) || (w_state_next == c_ST_ARST) ||
                         (w_state_next == c_ST_FAULT);
        w_locked_next  = (w_state_next == c_ST_LOCKED);
        w_busy_next    = (w_state_next == c_ST_ARST) || (w_state_next == c_ST_WAIT) ||
                         (w_state_next == c_ST_QUAL);
        w_fault_next   = (w_state_next == c_ST_FAULT);
        w_status_next  = {w_lol_field, w_retry_next, 1'b0, w_state_next,
                          w_sticky_next, w_fault_next, w_busy_next, w_locked_next};
    end

    assign pll_rst    = r_pll_rst;
    assign locked_out = r_locked;
    assign status_out = r_status;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Purpose  : Self-checking bench for pll_lock_sequencer. It applies a table
//            of directed vectors, hand-written corner sequences, and a
//            random phase that is compared against a phase/duration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

    localparam int RST  = 4;
    localparam int STB  = 8;
    localparam int TO   = 32;
    localparam int MAXR = 2;
`ifdef PLL_LOCK_SEQ_LOL_COUNT_EN
    localparam bit LOL_EN = 1'b1;
`else
    localparam bit LOL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cmd = 32'd0;
    logic        lock = 1'b0;
    logic        pll_rst;
    logic        locked_out;
    logic [31:0] status;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST),
        .STABLE_CYCLES (STB),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .cmd_in     (cmd),
        .pll_locked (lock),
        .pll_rst    (pll_rst),
        .locked_out (locked_out),
        .status_out (status)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Phases use the published state codes; m_tin counts cycles completed
    // in the current phase.
    int m_ph, m_tin, m_retry, m_lolc;
    bit m_sticky, m_cmdr, m_cmdp, m_s1, m_s2;

    task automatic model_reset();
        m_ph = 0; m_tin = 0; m_retry = 0; m_lolc = 0; m_sticky = 0;
        m_cmdr = 1; m_cmdp = 1; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic m_enter(int p);
        m_ph = p; m_tin = 0;
    endtask

    task automatic m_fail_attempt();
        if (m_retry < MAXR) begin m_retry++; m_enter(1); end
        else m_enter(5);
    endtask

    task automatic model_step(bit c0, bit ab, bit lr);
        bit st, lk;
        st = m_cmdr && !m_cmdp;
        lk = m_s2;
        if (ab) begin
            if (m_ph >= 1 && m_ph <= 4) m_enter(0);
        end else if (st) begin
            m_retry = 0; m_sticky = 0; m_lolc = 0; m_enter(1);
        end else begin
            case (m_ph)
                1: begin m_tin++; if (m_tin == RST) m_enter(2); end
                2: if (lk) m_enter(3);
                   else begin m_tin++; if (m_tin == TO) m_fail_attempt(); end
                3: if (!lk) m_enter(2);
                   else begin m_tin++; if (m_tin == STB) m_enter(4); end
                4: if (!lk) begin
                       m_sticky = 1;
                       if (m_lolc < 65535) m_lolc++;
                       m_fail_attempt();
                   end
                default: ;
            endcase
        end
        m_cmdp = m_cmdr; m_cmdr = c0;
        m_s2 = m_s1; m_s1 = lr;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[0]    = (m_ph == 4);
        s[1]    = (m_ph >= 1 && m_ph <= 3);
        s[2]    = (m_ph == 5);
        s[3]    = m_sticky;
        s[6:4]  = 3'(m_ph);
        s[15:8] = 8'(m_retry);
        if (LOL_EN) s[31:16] = 16'(m_lolc);
        return s;
    endfunction

    function automatic logic [31:0] lolf(int n);
        return LOL_EN ? (32'(n) << 16) : 32'd0;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string name, logic [31:0] st, logic r, logic l);
        chk({name, ".status"}, status, st);
        chk({name, ".pll_rst"}, {31'd0, pll_rst}, {31'd0, r});
        chk({name, ".locked"}, {31'd0, locked_out}, {31'd0, l});
    endtask

    // Advance n clock edges; sample point is 1 ns after each rising edge.
    task automatic tick(int n);
        bit c0, ab, lr;
        for (int i = 0; i < n; i++) begin
            c0 = cmd[0]; ab = cmd[1]; lr = lock;
            @(posedge clk);
            if (rst) model_reset();
            else model_step(c0, ab, lr);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic        lk;
        int          n;
        logic [31:0] st;
        logic        prst;
        logic        plk;
    } vec_t;

    vec_t tbl[14];
    int   run;

    initial begin
        // nominal bring-up, loss of lock, then abort racing start in WAIT_LOCK
        tbl[0]  = '{2'b01, 1'b0, 2, 32'h0000_0012, 1'b1, 1'b0};
        tbl[1]  = '{2'b00, 1'b0, 3, 32'h0000_0012, 1'b1, 1'b0};
        tbl[2]  = '{2'b00, 1'b0, 1, 32'h0000_0022, 1'b0, 1'b0};
        tbl[3]  = '{2'b00, 1'b0, 9, 32'h0000_0022, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 1'b1, 2, 32'h0000_0022, 1'b0, 1'b0};
        tbl[5]  = '{2'b00, 1'b1, 1, 32'h0000_0032, 1'b0, 1'b0};
        tbl[6]  = '{2'b00, 1'b1, 7, 32'h0000_0032, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 1'b1, 1, 32'h0000_0041, 1'b0, 1'b1};
        tbl[8]  = '{2'b00, 1'b0, 2, 32'h0000_0041, 1'b0, 1'b1};
        tbl[9]  = '{2'b00, 1'b0, 1, 32'h0000_011A | lolf(1), 1'b1, 1'b0};
        tbl[10] = '{2'b00, 1'b0, 4, 32'h0000_012A | lolf(1), 1'b0, 1'b0};
        tbl[11] = '{2'b11, 1'b0, 1, 32'h0000_0108 | lolf(1), 1'b1, 1'b0};
        tbl[12] = '{2'b11, 1'b0, 1, 32'h0000_0108 | lolf(1), 1'b1, 1'b0};
        tbl[13] = '{2'b01, 1'b0, 3, 32'h0000_0108 | lolf(1), 1'b1, 1'b0};

        model_reset();
        tick(3);
        chk_all("in_reset", 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
        tick(3);
        chk_all("post_reset_idle", 32'd0, 1'b1, 1'b0);

        for (int v = 0; v < 14; v++) begin
            cmd[1:0] = tbl[v].cmd;
            lock     = tbl[v].lk;
            tick(tbl[v].n);
            chk_all($sformatf("vec%0d", v), tbl[v].st, tbl[v].prst, tbl[v].plk);
        end

        // Timeout path: three attempts of 4 + 32 cycles, then FAULT
        cmd[1:0] = 2'b00; lock = 1'b0;
        tick(2);
        chk("idle_before_retry_run", status, 32'h0108 | lolf(1));
        cmd[0] = 1'b1;
        tick(1);
        for (int a = 0; a <= MAXR; a++) begin
            for (int i = 0; i < RST; i++) begin
                tick(1);
                chk_all($sformatf("att%0d_rst%0d", a, i), 32'h12 | (32'(a) << 8), 1'b1, 1'b0);
            end
            for (int i = 0; i < TO; i++) begin
                tick(1);
                chk($sformatf("att%0d_wait%0d", a, i), status, 32'h22 | (32'(a) << 8));
            end
        end
        tick(1);
        chk_all("fault_entry", 32'h0254, 1'b1, 1'b0);
        tick(5);
        chk_all("fault_hold", 32'h0254, 1'b1, 1'b0);

        // QUALIFY dropout: one low synchronized sample restarts qualification
        cmd[0] = 1'b0; tick(2);
        cmd[0] = 1'b1; tick(2);
        chk("q_start", status, 32'h12);
        tick(3);
        tick(1);
        chk("q_wait", status, 32'h22);
        lock = 1'b1;
        tick(3);
        chk("q_qual", status, 32'h32);
        tick(2);
        lock = 1'b0; tick(1);
        lock = 1'b1; tick(1);
        chk("q_still_qual", status, 32'h32);
        tick(1);
        chk("q_dropout_wait", status, 32'h22);
        tick(1);
        chk("q_requal", status, 32'h32);
        tick(7);
        chk_all("q_not_yet_locked", 32'h32, 1'b0, 1'b0);
        tick(1);
        chk_all("q_locked", 32'h41, 1'b0, 1'b1);

        // Asynchronous reset in LOCKED, no clock edge in between
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_reset", 32'd0, 1'b1, 1'b0);
        model_reset();
        tick(2);
        // start bit held high through reset release must not start
        cmd[1:0] = 2'b01;
        tick(1);
        rst = 1'b0;
        tick(4);
        chk_all("held_start_no_edge", 32'd0, 1'b1, 1'b0);

        // Random phase against the reference model
        run = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run == 0) begin
                lock = ($urandom_range(0, 9) < 7);
                run  = $urandom_range(1, 50);
            end
            run--;
            if ($urandom_range(0, 99) < 3) cmd[0] = ~cmd[0];
            cmd[1] = ($urandom_range(0, 199) < 2);
            cmd[31:2] = 30'($urandom);
            tick(1);
            chk("rnd.status", status, m_status());
            chk("rnd.pll_rst", {31'd0, pll_rst},
                {31'd0, (m_ph == 0 || m_ph == 1 || m_ph == 5)});
            chk("rnd.locked", {31'd0, locked_out}, {31'd0, (m_ph == 4)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst is held high per attempt (min 1).
REQ-002 Parameter STABLE_CYCLES, default 1024: consecutive synchronized lock-high cycles needed to declare lock.
REQ-003 Parameter TIMEOUT_CYCLES, default 65536: max cycles in WAIT_LOCK before an attempt fails.
REQ-004 Parameter MAX_RETRIES, default 3: re-attempts allowed after a failed attempt before FAULT (range 0..255).
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk_clk  in  1  system clock.
REQ-007 reset_reset  in  1  async active-high reset.
REQ-008 cmd_in  in  32  HPS PIO command word: bit0 start (rising edge), bit1 abort (level), bits[31:2] ignored.
REQ-009 pll_locked  in  1  raw PLL locked; asynchronous to clk_clk.
REQ-010 pll_rst  out  1  PLL areset, active-high.
REQ-011 locked_out  out  1  high only in LOCKED; gates downstream TDC/sensor logic.
REQ-012 status_out  out  32  HPS PIO status: bit0 locked_out, bit1 busy, bit2 fault, bit3 sticky loss-of-lock, bits[6:4] state code, bits[15:8] retry count, bits[31:16] per REQ-033.

Function
REQ-013 pll_locked passes through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle latency).
REQ-014 cmd_in[0] is registered once; start = registered bit high and previous registered value low.
REQ-015 States and codes: IDLE=0, ASSERT_RST=1, WAIT_LOCK=2, QUALIFY=3, LOCKED=4, FAULT=5.
REQ-016 IDLE: pll_rst=1, busy=0; start -> ASSERT_RST, retry count cleared, sticky LOL cleared.
REQ-017 ASSERT_RST: pll_rst=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK with pll_rst=0.
REQ-018 WAIT_LOCK: synchronized lock high -> QUALIFY; counter reaching TIMEOUT_CYCLES with no lock -> retry decision (REQ-021).
REQ-019 QUALIFY: lock high for STABLE_CYCLES consecutive cycles -> LOCKED; any low cycle -> WAIT_LOCK with timeout counter restarted.
REQ-020 LOCKED: locked_out=1; synchronized lock low -> set sticky LOL, retry decision (REQ-021).
REQ-021 Retry decision: retry count < MAX_RETRIES -> increment count, ASSERT_RST; else -> FAULT.
REQ-022 FAULT: pll_rst=1, fault=1, locked_out=0; exits only on start (-> ASSERT_RST, as REQ-016).
REQ-023 busy=1 in ASSERT_RST, WAIT_LOCK and QUALIFY only.
REQ-024 Abort (cmd_in[1]=1) in ASSERT_RST, WAIT_LOCK, QUALIFY or LOCKED -> IDLE next cycle; abort has priority over every other transition.
REQ-025 Start in any non-IDLE state restarts the sequence at ASSERT_RST as per REQ-016; start beats timeout/lock events in the same cycle.
REQ-026 Start and abort in the same cycle: abort wins.
REQ-027 One shared cycle counter sized for max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES); cleared on every state entry; never wraps.
REQ-028 Retry count saturates at 255.
REQ-029 All outputs registered; no combinational path from cmd_in or pll_locked to any output.

Reset
REQ-030 On reset assertion, asynchronously: state=IDLE, pll_rst=1, locked_out=0, status_out=0x00000000 except bit6..4=0, counters and synchronizer flops cleared.
REQ-031 After reset release, no sequence starts without a start edge; cmd_in[0] held high through reset does not count as an edge (edge register resets to 1).
REQ-032 Reset mid-sequence aborts immediately; pll_rst=1 within the same clock-free interval.

Configuration
REQ-033 Macro PLL_LOCK_SEQ_LOL_COUNT_EN defined: 16-bit saturating loss-of-lock event counter in status_out[31:16], cleared by reset and by start; undefined: status_out[31:16]=0 and no counter logic.

Verification (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-034 Start edge, pll_locked rises 10 cycles after pll_rst falls and stays high -> pll_rst high exactly 4 cycles; locked_out rises 2+8 cycles after lock rises; status_out[6:0]=0x41.
REQ-035 Start, pll_locked never high -> three attempts (retry count 0,1,2), each 4 rst + 32 wait cycles; then FAULT, status_out[2]=1, [15:8]=2, pll_rst=1.
REQ-036 In QUALIFY, one-cycle lock dropout after 5 high cycles -> return to WAIT_LOCK, locked_out delayed by a full 8 fresh high cycles.
REQ-037 In LOCKED, pll_locked low for 3 cycles -> sticky bit3=1, retry count=1, ASSERT_RST; with PLL_LOCK_SEQ_LOL_COUNT_EN, status_out[31:16]=1.
REQ-038 Abort and start asserted in the same cycle during WAIT_LOCK -> IDLE next cycle, pll_rst=1, busy=0; reset asserted in LOCKED -> all outputs at reset values without a clock edge.
